tribus_arbiter: RTL and testbench
=================================

Name: tribus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared tristate net.
- Every driver is a bufif1/bufif0-style cell or an nmos/pmos switch; this block produces their enables.
- Guarantees at most one enabled driver at a time and break-before-make turnaround between owners.
- Enables a pull cell whenever the net is undriven, and bounds each owner's tenure when others are waiting.

Parameters:
- N, 4: number of requesters/drivers (2..16).
- TURN_CYCLES, 1: cycles with all drivers off between any two ownerships (≥1; elaboration error if 0).
- MAX_HOLD, 16: cycles an owner may hold while another requester waits; 0 = unlimited.
- EN_ACTIVE_LOW, 0: 1 inverts drv_en for bufif0/pmos-style drivers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  N  per-requester bus request, level-sensitive.
- grant  output  N  one-hot-or-zero ownership indication, active-high.
- drv_en  output  N  driver enables: grant XOR {N{EN_ACTIVE_LOW}}.
- owner  output  clog2(N) (min 1)  index of current owner; valid while busy=1, else 0.
- busy  output  1  1 while some grant is asserted.
- pull_en  output  1  1 when no driver is enabled; drives the pullup/pulldown keeper.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, grant=0, drv_en={N{EN_ACTIVE_LOW}}, owner=0, busy=0, pull_en=1.
  - Round-robin pointer=N-1, so requester 0 has first priority.
  - Reset mid-OWN or mid-TURN releases the net on the same edge; no turnaround is owed after reset.
- All outputs are registered. grant, drv_en, busy, owner and pull_en derive only from state and owner, never combinationally from req.
- Pick function: the first set req bit searching from pointer+1 upward, wrapping modulo N.
- State IDLE:
  - If any req is set at an edge: latch target=pick, load turn counter=TURN_CYCLES, go to TURN.
  - Otherwise stay in IDLE.
- State TURN (all grants 0, pull_en=1):
  - The counter decrements each edge.
  - On the edge where it reaches 0: if req[target]=1, go to OWN with owner=target, pointer=target, hold counter=0. If req[target]=0, go to IDLE.
  - The target is fixed for the whole of TURN; new requests do not retarget.
- State OWN (grant[owner]=1, busy=1, pull_en=0):
  - The hold counter increments each edge and saturates at MAX_HOLD.
  - Release: if req[owner]=0 at an edge, grant drops on that edge. Then, if any other req is set, latch a new target and go to TURN; else go to IDLE.
  - Preempt: if MAX_HOLD≠0, hold counter==MAX_HOLD and any other req is set, drop grant and go to TURN toward pick. The owner is excluded from pick because the pointer equals the owner.
  - If no other requester is waiting, ownership continues indefinitely regardless of the hold counter.
  - Release and preempt on the same edge are handled as release.
- Latency:
  - A req first sampled high at edge E0 with the arbiter in IDLE produces grant high in the cycle after edge E0+TURN_CYCLES.
  - Handover: the old grant falls at edge Er and the new grant rises at edge Er+TURN_CYCLES.
- Invariants (required of the implementation, checked by the bench):
  - popcount(grant) ≤ 1 every cycle.
  - pull_en == ~|grant.
  - Every 1→0 grant transition is followed by at least TURN_CYCLES all-zero cycles before any grant rises.
  - owner == index of the set grant bit.
- Widths: the hold counter is clog2(MAX_HOLD+1) bits and the turn counter is clog2(TURN_CYCLES+1) bits; neither wraps.

Test Plan:
- Reset with req=4'b1111, N=4, T=1 → pull_en=1 and grant=0 throughout reset; req[0] sampled at E0 after release → grant=4'b0001 after E1, drv_en=4'b0001, pull_en=0.
- Round robin: req=4'b1111 held, each owner drops req for one cycle after gaining the grant → grant order 0001,0010,0100,1000,0001, with exactly one all-zero cycle between owners.
- Preempt: MAX_HOLD=4, req[2] held, req[3] raised at cycle 2 of ownership → grant[2] falls after 4 OWN cycles, one idle cycle follows, then grant=4'b1000; with no competitor, req[2] alone keeps grant for 50+ cycles.
- Abandon: req[1] pulses for one cycle from IDLE, T=3 → TURN for 3 cycles, return to IDLE, grant stays 0, pull_en stays 1.
- EN_ACTIVE_LOW=1, T=2 → drv_en resets to 4'b1111; owner 2 granted → drv_en=4'b1011; a handover shows 2 cycles of drv_en=4'b1111.
- Reset asserted mid-OWN → drv_en returns to its inactive value on that edge; after release a new grant follows normal IDLE latency.

Source files
------------

// File: rtl/tribus_arbiter.sv
// Round-robin owner sequencer for a shared tristate net: one driver enable at a
// time, TURN_CYCLES all-off cycles between owners, and a keeper enable while undriven.
module tribus_arbiter #(
  parameter int N             = 4,
  parameter int TURN_CYCLES   = 1,
  parameter int MAX_HOLD      = 16,
  parameter int EN_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         drv_en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 pull_en
);

  localparam int OW = $clog2(N);
  localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [OW-1:0] PTR_RST   = OW'(N - 1);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("tribus_arbiter: N must be in 2..16");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("tribus_arbiter: TURN_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t        state, state_n;
  logic [OW-1:0] owner_q, owner_n, ptr, ptr_n, target, target_n, next_pick;
  logic [TW-1:0] turn_cnt, turn_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [N-1:0]  own_mask, others;
  logic          preempt;

  // First set request strictly after the pointer, wrapping; the pointer itself is searched last.
  function automatic logic [OW-1:0] pick(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] res, idx;
    logic          found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = OW'((int'(p) + 1 + i) % N);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_q  <= '0;
      ptr      <= PTR_RST;
      target   <= '0;
      turn_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      owner_q  <= owner_n;
      ptr      <= ptr_n;
      target   <= target_n;
      turn_cnt <= turn_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner_q;
    ptr_n     = ptr;
    target_n  = target;
    turn_n    = turn_cnt;
    hold_n    = hold_cnt;
    preempt   = 1'b0;
    own_mask  = '0;
    own_mask[owner_q] = 1'b1;
    others    = req & ~own_mask;
    next_pick = pick(req, ptr);
    case (state)
      IDLE: begin
        if (|req) begin
          target_n = next_pick;
          turn_n   = TURN_LOAD;
          state_n  = TURN;
        end
      end
      TURN: begin
        turn_n = turn_cnt - TW'(1);
        if (turn_cnt == TW'(1)) begin
          if (req[target]) begin
            state_n = OWN;
            owner_n = target;
            ptr_n   = target;
            hold_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      OWN: begin
        if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) hold_n = hold_cnt + HW'(1);
        // Preemption fires on the edge where tenure reaches MAX_HOLD granted cycles.
        preempt = (MAX_HOLD != 0) && (hold_n == HOLD_MAX) && (|others);
        if (!req[owner_q]) begin
          if (|req) begin
            target_n = next_pick;
            turn_n   = TURN_LOAD;
            state_n  = TURN;
          end else begin
            state_n = IDLE;
          end
        end else if (preempt) begin
          target_n = next_pick;
          turn_n   = TURN_LOAD;
          state_n  = TURN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state == OWN) grant = own_mask;
  end

  assign drv_en  = grant ^ {N{EN_ACTIVE_LOW != 0}};
  assign busy    = (state == OWN);
  assign pull_en = ~busy;
  assign owner   = busy ? owner_q : '0;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: three configurations share one request stream and are
// compared every cycle against a tenure/queue-level model, plus directed literal checks.
module tb_tribus_arbiter;
  localparam int N  = 4;
  localparam int NI = 3;

  int tc[NI]  = '{1, 3, 2};
  int mh[NI]  = '{4, 0, 16};
  int eal[NI] = '{0, 0, 1};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] grant_s [NI];
  logic [N-1:0] drv_s   [NI];
  logic [1:0]   owner_s [NI];
  logic         busy_s  [NI];
  logic         pull_s  [NI];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  logic [N-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  tribus_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(4), .EN_ACTIVE_LOW(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_s[0]), .drv_en(drv_s[0]),
    .owner(owner_s[0]), .busy(busy_s[0]), .pull_en(pull_s[0]));
  tribus_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(0), .EN_ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_s[1]), .drv_en(drv_s[1]),
    .owner(owner_s[1]), .busy(busy_s[1]), .pull_en(pull_s[1]));
  tribus_arbiter #(.N(4), .TURN_CYCLES(2), .MAX_HOLD(16), .EN_ACTIVE_LOW(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_s[2]), .drv_en(drv_s[2]),
    .owner(owner_s[2]), .busy(busy_s[2]), .pull_en(pull_s[2]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: mode 0 idle, 1 turnaround, 2 owned; tenure = granted cycles so far
  int m_mode[NI], m_rem[NI], m_tgt[NI], m_own[NI], m_ptr[NI], m_ten[NI];

  function automatic bit has(input logic [N-1:0] r, input int i);
    return ((r >> i) & N'(1)) != '0;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++)
      if (has(r, (p + i) % N)) return (p + i) % N;
    return 0;
  endfunction

  task automatic start_turn(input int k);
    m_tgt[k]  = pick(req, m_ptr[k]);
    m_rem[k]  = tc[k];
    m_mode[k] = 1;
  endtask

  task automatic model_step(input int k);
    logic [N-1:0] oth;
    if (!rst_n) begin
      m_mode[k] = 0; m_ptr[k] = N - 1; m_own[k] = 0; m_ten[k] = 0; m_rem[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (req != '0) start_turn(k);
    end else if (m_mode[k] == 1) begin
      m_rem[k]--;
      if (m_rem[k] == 0) begin
        if (has(req, m_tgt[k])) begin
          m_mode[k] = 2; m_own[k] = m_tgt[k]; m_ptr[k] = m_tgt[k]; m_ten[k] = 1;
        end else begin
          m_mode[k] = 0;
        end
      end
    end else begin
      oth = req & ~(N'(1) << m_own[k]);
      if (!has(req, m_own[k])) begin
        if (req != '0) start_turn(k);
        else m_mode[k] = 0;
      end else if (mh[k] != 0 && m_ten[k] >= mh[k] && oth != '0) begin
        start_turn(k);
      end else begin
        m_ten[k]++;
      end
    end
  endtask

  always @(posedge clk)
    for (int k = 0; k < NI; k++) model_step(k);

  // per-cycle compare against the model plus structural invariants
  logic [N-1:0] cmp_eg;
  logic [N-1:0] prev_g [NI];
  int           zrun   [NI];
  bit           fell   [NI];

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < NI; k++) begin
        cmp_eg = (m_mode[k] == 2) ? (N'(1) << m_own[k]) : '0;
        check($sformatf("u%0d grant", k), grant_s[k], cmp_eg);
        check($sformatf("u%0d drv_en", k), drv_s[k], cmp_eg ^ {N{eal[k] != 0}});
        check($sformatf("u%0d owner", k), owner_s[k], (m_mode[k] == 2) ? m_own[k] : 0);
        check($sformatf("u%0d busy", k), busy_s[k], m_mode[k] == 2);
        check($sformatf("u%0d pull_en", k), pull_s[k], m_mode[k] != 2);
        check($sformatf("u%0d inv_onehot", k), $countones(grant_s[k]) <= 1, 1);
        check($sformatf("u%0d inv_pull", k), pull_s[k] == ~|grant_s[k], 1);
        if (busy_s[k]) check($sformatf("u%0d inv_owner", k), grant_s[k], N'(1) << owner_s[k]);
        if (grant_s[k] != '0) begin
          if (prev_g[k] == '0 && fell[k]) check($sformatf("u%0d inv_gap", k), zrun[k] >= tc[k], 1);
          zrun[k] = 0;
        end else begin
          if (prev_g[k] != '0) begin
            fell[k] = 1'b1;
            zrun[k] = 0;
          end
          zrun[k]++;
        end
        prev_g[k] = grant_s[k];
      end
    end
  end

  // driver tasks
  task automatic wait_grant(input int k, output int z);
    bit got;
    got = 1'b0;
    z   = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (grant_s[k] != '0) got = 1'b1;
      else begin
        z++;
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_grant u%0d: no grant within 40 cycles", k);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic settle();
    req = '0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int z, hold, cnt;
    logic [N-1:0] exp_g;

    // reset with all requests high
    rst_n = 1'b0;
    req   = 4'hF;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst grant", grant_s[0], 4'b0000);
      check("rst pull_en", pull_s[0], 1'b1);
      check("rst drv_en_al", drv_s[2], 4'b1111);
      @(negedge clk);
    end
    req   = 4'b0001;
    rst_n = 1'b1;
    @(negedge clk);
    check("first turn grant", grant_s[0], 4'b0000);
    @(negedge clk);
    check("first grant", grant_s[0], 4'b0001);
    check("first drv_en", drv_s[0], 4'b0001);
    check("first pull_en", pull_s[0], 1'b0);
    settle();

    // round robin with each owner dropping its request once granted
    do_reset();
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    req = 4'hF;
    wait_grant(0, z);
    for (int g = 0; g < 5; g++) begin
      exp_g = exp_q.pop_front();
      check("rr grant", grant_s[0], exp_g);
      if (g > 0) check("rr gap", z, 1);
      req = 4'hF & ~grant_s[0];
      @(negedge clk);
      req = 4'hF;
      wait_grant(0, z);
    end
    settle();

    // preemption after MAX_HOLD cycles, then an uncontested long hold
    req = 4'b0100;
    wait_grant(0, z);
    hold = 1;
    @(negedge clk);
    req = 4'b1100;
    while (grant_s[0] == 4'b0100 && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    check("preempt hold", hold, 4);
    wait_grant(0, z);
    check("preempt gap", z, 1);
    check("preempt new owner", grant_s[0], 4'b1000);
    req = 4'b0100;
    @(negedge clk);
    wait_grant(0, z);
    cnt = 0;
    for (int i = 0; i < 55; i++) begin
      if (grant_s[0] == 4'b0100) cnt++;
      @(negedge clk);
    end
    check("solo hold", cnt, 55);
    settle();

    // abandoned turnaround
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      check("abandon grant", grant_s[1], 4'b0000);
      check("abandon pull_en", pull_s[1], 1'b1);
      @(negedge clk);
    end
    settle();

    // active-low enables and a two-cycle handover
    req = 4'b0100;
    wait_grant(2, z);
    check("al latency", z, 3);
    check("al drv_en own2", drv_s[2], 4'b1011);
    req = 4'b1000;
    @(negedge clk);
    wait_grant(2, z);
    check("al handover gap", z, 2);
    check("al drv_en own3", drv_s[2], 4'b0111);
    settle();

    // reset during ownership
    req = 4'b0001;
    wait_grant(0, z);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst drv_en", drv_s[0], 4'b0000);
    check("midrst pull_en", pull_s[0], 1'b1);
    check("midrst drv_en_al", drv_s[2], 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(0, z);
    check("midrst relatency", z, 2);
    settle();

    // randomized traffic with sticky requests and rare resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
